heap_memory: RTL
================

# heap_memory

Parametrised Lisp heap store with a single-cycle read/write port and a bump allocator that returns NIL-filled cells. It replaces the fixed 256×16 read-only heap and sits between the evaluator and block RAM. The evaluator reads and writes cells through the access port and requests fresh cells through the allocation port. Words below `HeapStart` hold the preloaded ROM/NIL image and are write-protected.

## Interface
- `DataWidth`, 16: cell width in bits; must be ≥ 16.
- `Depth`, 256: number of cells; power of two, ≥ 16.
- `HeapStart`, 5: first allocatable address; words 0..HeapStart-1 hold the preloaded image.
- `MaxAlloc`, 8: largest single allocation, in words.
- `AddrWidth`, $clog2(Depth): derived; not overridden.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request, qualified by `ready`.
- `we`  in  1  1 = write, 0 = read.
- `addr_in`  in  AddrWidth  cell address.
- `data_in`  in  DataWidth  write data.
- `ready`  out  1  access port can accept a request this cycle.
- `data_ready`  out  1  one-cycle pulse: `data_out` is valid (reads only).
- `data_out`  out  DataWidth  read data; holds its value until the next read.
- `wr_fault`  out  1  one-cycle pulse: a write to `addr < HeapStart` was dropped.
- `alloc_req`  in  1  allocation request, qualified by `alloc_ready`.
- `alloc_words`  in  $clog2(MaxAlloc+1)  number of words to allocate.
- `alloc_ready`  out  1  allocator can accept a request this cycle.
- `alloc_done`  out  1  one-cycle pulse: `alloc_ptr` is valid and the cells are cleared.
- `alloc_err`  out  1  one-cycle pulse: request rejected.
- `alloc_ptr`  out  AddrWidth  base address of the last successful allocation.
- `heap_reset`  in  1  bulk free: returns `free_ptr` to `HeapStart`.
- `free_count`  out  AddrWidth+1  equals Depth − free_ptr.

## Operation
- States:
  - IDLE: accepts access requests and allocations.
  - CLEAR: writes `LISP_NIL` into allocated words.
- Access port:
  - `ready` = (state == IDLE).
  - A request is accepted when `req && ready`.
  - Read: `data_out` ← mem[addr_in] and `data_ready` pulses on the next cycle.
  - Write with `addr_in ≥ HeapStart`: mem[addr_in] ← `data_in`.
  - Write with `addr_in < HeapStart`: no RAM write; `wr_fault` pulses on the next cycle.
- Allocation port:
  - `alloc_ready` = IDLE && !req, so the access port has priority.
  - A request is accepted when `alloc_req && alloc_ready`.
  - Reject, with `alloc_err` pulsing on the next cycle and no state change, when `alloc_words` == 0, `alloc_words` > MaxAlloc, or free_ptr + alloc_words > Depth. Compute the sum at AddrWidth+1 bits with no wrap.
  - Otherwise: base ← free_ptr, free_ptr ← free_ptr + alloc_words, clear counter ← 0, go to CLEAR.
- CLEAR:
  - Each cycle, write `LISP_NIL` to base + counter, then increment the counter.
  - After writing word `alloc_words`−1: `alloc_ptr` ← base, pulse `alloc_done`, return to IDLE.
  - `req` and `alloc_req` are held off during CLEAR via `ready`/`alloc_ready` low.
- `heap_reset`:
  - Sampled only in IDLE; sets free_ptr ← HeapStart on the next edge.
  - If asserted with an accepted `alloc_req`, `heap_reset` wins and the allocation is dropped silently: no done, no err.
  - Ignored in CLEAR.
- Exact fit: free_ptr + alloc_words == Depth succeeds, leaving `free_count` at 0.
- RAM contents initialise to the package image: word 0 = NIL, word 1 = NIL, word 2 = 16'h789A, word 3 = number header.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state = IDLE; free_ptr = HeapStart.
  - `data_out`, `alloc_ptr` = 0; all pulses = 0.
  - `ready` = `alloc_ready` = 1.
  - RAM contents are not reset.
- Reset mid-CLEAR aborts the clear. The partially cleared words keep their contents; free_ptr returns to HeapStart.
- Read latency: 1 cycle. Back-to-back reads every cycle in IDLE.
- Allocation latency, from accept edge to `alloc_done`: alloc_words + 1 cycles.
- Allocation throughput: the next request can be accepted the cycle `alloc_done` is high.
- `free_count` updates the cycle after an allocation is accepted.

## Structure
- Package `lisp_defs` holds:
  - `LISP_NIL`, `TYPE_NUMBER` and the cell header field typedef.
  - The `heap_state_e` enum (IDLE, CLEAR).
  - The boot image constants used for initialisation.
- Sub-module `heap_ram`: a single-port synchronous RAM (`ram_style = "block"`) with write enable and a 1-cycle registered read, parametrised by DataWidth/Depth. `heap_memory` instantiates it; all arbitration, the FSM and `free_ptr` live in `heap_memory`.

## Test plan
- Reset, then read addr 2 → `data_ready` pulses 1 cycle later with `data_out` = 16'h789A; `free_count` = 251.
- Write 16'h1234 to addr 1 → `wr_fault` pulses; a read of addr 1 still returns NIL. Write 16'hBEEF to addr 20, read addr 20 → 16'hBEEF.
- Allocation of 3 words after reset:
  - Preload addr 5..7 with 16'hFFFF.
  - Request 3 words → `alloc_done` 4 cycles after accept, `alloc_ptr` = 5.
  - Reads of 5..7 return NIL; `free_count` = 248.
- Out of memory:
  - Allocate until free_ptr = 250, then request 8 → `alloc_err`, `free_count` stays 6.
  - Request 6 → success, `alloc_ptr` = 250, `free_count` = 0.
  - Requests of 0 or 9 words → `alloc_err`.
- `req` and `alloc_req` asserted in the same cycle in IDLE → the read is served and `alloc_ready` is 0. The allocation is accepted the next cycle; `ready` stays 0 throughout CLEAR.
- `rst_n` pulsed low during CLEAR of a 6-word allocation → no `alloc_done`; `free_count` = 251; the next 1-word allocation returns `alloc_ptr` = 5.

Source files
------------

// File: rtl/heap_memory_pkg.sv
// Lisp cell encodings, heap FSM states and the boot image that occupies the
// write-protected words below the first allocatable address.
package lisp_defs;

  typedef struct packed {
    logic [3:0]  tag;
    logic [11:0] payload;
  } cell_hdr_t;

  localparam logic [3:0]  TYPE_NUMBER = 4'h2;
  localparam logic [15:0] LISP_NIL    = 16'h0000;

  typedef enum logic {
    IDLE,
    CLEAR
  } heap_state_e;

  localparam logic [15:0] BOOT_WORD2   = 16'h789A;
  localparam cell_hdr_t   BOOT_NUM_HDR = '{tag: TYPE_NUMBER, payload: 12'h000};

  // Every image word not listed explicitly is NIL.
  function automatic logic [15:0] boot_word(input int unsigned idx);
    case (idx)
      2:       return BOOT_WORD2;
      3:       return BOOT_NUM_HDR;
      default: return LISP_NIL;
    endcase
  endfunction

endpackage

// File: rtl/heap_memory_ram.sv
// Single-port synchronous block RAM: write-first-free, one-cycle registered read.
// The read register holds its value until the next read and resets to zero.
module heap_ram #(
  parameter int DataWidth = 16,
  parameter int Depth     = 256,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata
);

  (* ram_style = "block" *) logic [DataWidth-1:0] mem [Depth];

  logic [DataWidth-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/heap_memory.sv
// Lisp heap store: single-cycle access port with write-protected boot image,
// plus a bump allocator that NIL-fills each new block one word per cycle.
module heap_memory
  import lisp_defs::*;
#(
  parameter int DataWidth = 16,
  parameter int Depth     = 256,
  parameter int HeapStart = 5,
  parameter int MaxAlloc  = 8,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req,
  input  logic                          we,
  input  logic [AddrWidth-1:0]          addr_in,
  input  logic [DataWidth-1:0]          data_in,
  output logic                          ready,
  output logic                          data_ready,
  output logic [DataWidth-1:0]          data_out,
  output logic                          wr_fault,
  input  logic                          alloc_req,
  input  logic [$clog2(MaxAlloc+1)-1:0] alloc_words,
  output logic                          alloc_ready,
  output logic                          alloc_done,
  output logic                          alloc_err,
  output logic [AddrWidth-1:0]          alloc_ptr,
  input  logic                          heap_reset,
  output logic [AddrWidth:0]            free_count
);

  localparam int CW = $clog2(MaxAlloc + 1);
  localparam logic [AddrWidth:0]   DEPTH_W = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth:0]   START_W = (AddrWidth + 1)'(HeapStart);
  localparam logic [AddrWidth-1:0] START_A = AddrWidth'(HeapStart);
  localparam logic [CW-1:0]        MAX_W   = CW'(MaxAlloc);

  heap_state_e          state_d, state_q;
  logic [AddrWidth:0]   free_ptr_d, free_ptr_q;
  logic [AddrWidth-1:0] base_d, base_q, alloc_ptr_d, alloc_ptr_q;
  logic [CW-1:0]        cnt_d, cnt_q, len_d, len_q;
  logic                 data_ready_d, data_ready_q, wr_fault_d, wr_fault_q;
  logic                 alloc_done_d, alloc_done_q, alloc_err_d, alloc_err_q;
  logic                 rd_rom_d, rd_rom_q;
  logic [DataWidth-1:0] rom_d, rom_q;

  logic                 ram_en, ram_we;
  logic [AddrWidth-1:0] ram_addr;
  logic [DataWidth-1:0] ram_wdata, ram_rdata;
  logic                 acc_go, alloc_go, alloc_bad;
  logic [AddrWidth:0]   alloc_end;

  assign ready       = (state_q == IDLE);
  assign alloc_ready = ready && !req;
  assign acc_go      = req && ready;
  assign alloc_go    = alloc_req && alloc_ready;
  // Sum carries one extra bit so an oversized request cannot wrap past Depth.
  assign alloc_end   = free_ptr_q + (AddrWidth + 1)'(alloc_words);
  assign alloc_bad   = (alloc_words == '0) || (alloc_words > MAX_W) || (alloc_end > DEPTH_W);

  always_comb begin
    state_d      = state_q;
    free_ptr_d   = free_ptr_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    alloc_ptr_d  = alloc_ptr_q;
    rd_rom_d     = rd_rom_q;
    rom_d        = rom_q;
    data_ready_d = 1'b0;
    wr_fault_d   = 1'b0;
    alloc_done_d = 1'b0;
    alloc_err_d  = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = addr_in;
    ram_wdata    = data_in;
    case (state_q)
      IDLE: begin
        if (acc_go) begin
          ram_en = 1'b1;
          if (we) begin
            if (addr_in >= START_A) ram_we = 1'b1;
            else                    wr_fault_d = 1'b1;
          end else begin
            data_ready_d = 1'b1;
            // Image words are served from the package constants, not the RAM.
            rd_rom_d     = (addr_in < START_A);
            rom_d        = DataWidth'(boot_word(32'(addr_in)));
          end
        end
        if (heap_reset) begin
          free_ptr_d = START_W;
        end else if (alloc_go) begin
          if (alloc_bad) begin
            alloc_err_d = 1'b1;
          end else begin
            base_d     = free_ptr_q[AddrWidth-1:0];
            free_ptr_d = alloc_end;
            cnt_d      = '0;
            len_d      = alloc_words;
            state_d    = CLEAR;
          end
        end
      end
      CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = base_q + AddrWidth'(cnt_q);
        ram_wdata = DataWidth'(LISP_NIL);
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == len_q - CW'(1)) begin
          alloc_ptr_d  = base_q;
          alloc_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      free_ptr_q   <= START_W;
      base_q       <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      alloc_ptr_q  <= '0;
      rd_rom_q     <= 1'b0;
      rom_q        <= '0;
      data_ready_q <= 1'b0;
      wr_fault_q   <= 1'b0;
      alloc_done_q <= 1'b0;
      alloc_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      free_ptr_q   <= free_ptr_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      alloc_ptr_q  <= alloc_ptr_d;
      rd_rom_q     <= rd_rom_d;
      rom_q        <= rom_d;
      data_ready_q <= data_ready_d;
      wr_fault_q   <= wr_fault_d;
      alloc_done_q <= alloc_done_d;
      alloc_err_q  <= alloc_err_d;
    end
  end

  heap_ram #(
    .DataWidth(DataWidth),
    .Depth    (Depth),
    .AddrWidth(AddrWidth)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign data_out   = rd_rom_q ? rom_q : ram_rdata;
  assign data_ready = data_ready_q;
  assign wr_fault   = wr_fault_q;
  assign alloc_done = alloc_done_q;
  assign alloc_err  = alloc_err_q;
  assign alloc_ptr  = alloc_ptr_q;
  assign free_count = DEPTH_W - free_ptr_q;

endmodule
